// File: rtl/acc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : acc_sequencer_if
//  Description : Operation, memory, ALU and writeback signal bundle for the
//                accumulator sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface acc_sequencer_if;
  logic       op_valid;
  logic [2:0] op_class;
  logic       op_ready;
  logic       mem_rd_req;
  logic       mem_rd_ack;
  logic       alu_start;
  logic       alu_done;
  logic [1:0] acc_sel;
  logic       acc_write;
  logic       reg_write;
  logic [7:0] wb_count;
  logic       timeout_err;
  logic       illegal_op;
  logic       halted;

  // Drives operations and memory/ALU responses; observes sequencer outputs.
  modport master (
    output op_valid, op_class, mem_rd_ack, alu_done,
    input  op_ready, mem_rd_req, alu_start, acc_sel, acc_write, reg_write,
           wb_count, timeout_err, illegal_op, halted
  );

  // Sequencer side.
  modport slave (
    input  op_valid, op_class, mem_rd_ack, alu_done,
    output op_ready, mem_rd_req, alu_start, acc_sel, acc_write, reg_write,
           wb_count, timeout_err, illegal_op, halted
  );
endinterface
`default_nettype wire

// File: rtl/acc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : acc_sequencer
//  Description : Accumulator load/ALU/store sequencer. Accepts one decoded
//                operation at a time in IDLE, waits for memory or ALU with a
//                bounded timeout, and issues a single accumulator writeback.
//  Revision    : 1.0  initial release
// ============================================================================
module acc_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  wire logic        clk,
  input  wire logic        reset,
  acc_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MEM_WAIT  = 3'd1,
    S_ALU_WAIT  = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  localparam logic [2:0] c_OP_LDI  = 3'd0;
  localparam logic [2:0] c_OP_LDR  = 3'd1;
  localparam logic [2:0] c_OP_LDM  = 3'd2;
  localparam logic [2:0] c_OP_ALU  = 3'd3;
  localparam logic [2:0] c_OP_STA  = 3'd4;
  localparam logic [2:0] c_OP_NOP  = 3'd5;
  localparam logic [2:0] c_OP_HALT = 3'd6;

  localparam logic [1:0] c_SEL_IMM = 2'b00;
  localparam logic [1:0] c_SEL_REG = 2'b01;
  localparam logic [1:0] c_SEL_MEM = 2'b10;
  localparam logic [1:0] c_SEL_ALU = 2'b11;

  // Counter value held during the last permitted wait cycle; a response in
  // that cycle still completes normally.
  localparam logic [7:0] c_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     r_state;
  logic [7:0] r_wait_cnt;
  logic       r_mem_rd_req;
  logic       r_alu_start;
  logic [1:0] r_acc_sel;
  logic       r_acc_write;
  logic       r_reg_write;
  logic [7:0] r_wb_count;
  logic       r_timeout_err;
  logic       r_illegal_op;
  logic       r_halted;

  state_t     w_state;
  logic [7:0] w_wait_cnt;
  logic       w_mem_rd_req;
  logic       w_alu_start;
  logic [1:0] w_acc_sel;
  logic       w_acc_write;
  logic       w_reg_write;
  logic [7:0] w_wb_count;
  logic       w_timeout_err;
  logic       w_illegal_op;
  logic       w_halted;
  logic       w_accept;

  assign w_accept = bus.op_valid && (r_state == S_IDLE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state       = r_state;
    w_wait_cnt    = r_wait_cnt;
    w_mem_rd_req  = r_mem_rd_req;
    w_alu_start   = 1'b0;
    w_acc_sel     = r_acc_sel;
    w_acc_write   = 1'b0;
    w_reg_write   = 1'b0;
    w_wb_count    = r_wb_count;
    w_timeout_err = r_timeout_err;
    w_illegal_op  = r_illegal_op;
    w_halted      = r_halted;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (bus.op_class)
            c_OP_LDI: begin
              w_acc_sel = c_SEL_IMM;
              w_state   = S_WRITEBACK;
            end
            c_OP_LDR: begin
              w_acc_sel = c_SEL_REG;
              w_state   = S_WRITEBACK;
            end
            c_OP_LDM: begin
              w_mem_rd_req = 1'b1;
              w_wait_cnt   = 8'd0;
              w_state      = S_MEM_WAIT;
            end
            c_OP_ALU: begin
              w_alu_start = 1'b1;
              w_wait_cnt  = 8'd0;
              w_state     = S_ALU_WAIT;
            end
            c_OP_STA: begin
              w_reg_write = 1'b1;
            end
            c_OP_NOP: begin
            end
            c_OP_HALT: begin
              w_halted = 1'b1;
              w_state  = S_HALT;
            end
            default: begin
              w_illegal_op = 1'b1;
            end
          endcase
        end
      end
      S_MEM_WAIT: begin
        if (bus.mem_rd_ack) begin
          w_mem_rd_req = 1'b0;
          w_acc_sel    = c_SEL_MEM;
          w_state      = S_WRITEBACK;
        end else if (r_wait_cnt == c_WAIT_LAST) begin
          w_mem_rd_req  = 1'b0;
          w_timeout_err = 1'b1;
          w_state       = S_IDLE;
        end else begin
          w_wait_cnt = r_wait_cnt + 8'd1;
        end
      end
      S_ALU_WAIT: begin
        if (bus.alu_done) begin
          w_acc_sel = c_SEL_ALU;
          w_state   = S_WRITEBACK;
        end else if (r_wait_cnt == c_WAIT_LAST) begin
          w_timeout_err = 1'b1;
          w_state       = S_IDLE;
        end else begin
          w_wait_cnt = r_wait_cnt + 8'd1;
        end
      end
      S_WRITEBACK: begin
        w_state = S_IDLE;
      end
      S_HALT: begin
        w_state = S_HALT;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    // The write pulse is registered on the edge that enters WRITEBACK, so it
    // coincides exactly with the single WRITEBACK cycle.
    if ((w_state == S_WRITEBACK) && (r_state != S_WRITEBACK)) begin
      w_acc_write = 1'b1;
      w_wb_count  = r_wb_count + 8'd1;
    end
  end

  // Registered outputs and wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt    <= 8'd0;
      r_mem_rd_req  <= 1'b0;
      r_alu_start   <= 1'b0;
      r_acc_sel     <= c_SEL_IMM;
      r_acc_write   <= 1'b0;
      r_reg_write   <= 1'b0;
      r_wb_count    <= 8'd0;
      r_timeout_err <= 1'b0;
      r_illegal_op  <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_wait_cnt    <= w_wait_cnt;
      r_mem_rd_req  <= w_mem_rd_req;
      r_alu_start   <= w_alu_start;
      r_acc_sel     <= w_acc_sel;
      r_acc_write   <= w_acc_write;
      r_reg_write   <= w_reg_write;
      r_wb_count    <= w_wb_count;
      r_timeout_err <= w_timeout_err;
      r_illegal_op  <= w_illegal_op;
      r_halted      <= w_halted;
    end
  end

  assign bus.op_ready    = (r_state == S_IDLE);
  assign bus.mem_rd_req  = r_mem_rd_req;
  assign bus.alu_start   = r_alu_start;
  assign bus.acc_sel     = r_acc_sel;
  assign bus.acc_write   = r_acc_write;
  assign bus.reg_write   = r_reg_write;
  assign bus.wb_count    = r_wb_count;
  assign bus.timeout_err = r_timeout_err;
  assign bus.illegal_op  = r_illegal_op;
  assign bus.halted      = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_acc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acc_sequencer
//  Description : Directed self-checking bench for acc_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_acc_sequencer;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  acc_sequencer_if bus ();

  acc_sequencer #(.MEM_TIMEOUT(15)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total = n_total + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Offer one operation for a single rising edge; returns at the negedge
  // of the cycle following that edge.
  task automatic issue(input logic [2:0] cls);
    bus.op_valid = 1'b1;
    bus.op_class = cls;
    tick();
    bus.op_valid = 1'b0;
    bus.op_class = 3'd5;
  endtask

  initial begin
    n_total        = 0;
    n_bad          = 0;
    reset          = 1'b1;
    bus.op_valid   = 1'b0;
    bus.op_class   = 3'd5;
    bus.mem_rd_ack = 1'b0;
    bus.alu_done   = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_ready",   32'(bus.op_ready),    1);
    chk("rst_sel",     32'(bus.acc_sel),     0);
    chk("rst_wbcnt",   32'(bus.wb_count),    0);
    chk("rst_halted",  32'(bus.halted),      0);
    chk("rst_memreq",  32'(bus.mem_rd_req),  0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", 32'(bus.op_ready), 1);

    // LDI then LDR, one load every two cycles
    issue(3'd0);
    chk("ldi_write", 32'(bus.acc_write), 1);
    chk("ldi_sel",   32'(bus.acc_sel),   0);
    chk("ldi_ready", 32'(bus.op_ready),  0);
    chk("ldi_wbcnt", 32'(bus.wb_count),  1);
    tick();
    chk("ldi_write_end", 32'(bus.acc_write), 0);
    issue(3'd1);
    chk("ldr_write", 32'(bus.acc_write), 1);
    chk("ldr_sel",   32'(bus.acc_sel),   1);
    chk("ldr_wbcnt", 32'(bus.wb_count),  2);
    tick();

    // Stray ack in IDLE is ignored
    bus.mem_rd_ack = 1'b1;
    tick();
    bus.mem_rd_ack = 1'b0;
    chk("stray_ack_write", 32'(bus.acc_write), 0);
    chk("stray_ack_sel",   32'(bus.acc_sel),   1);
    tick();

    // LDM, ack in the fourth wait cycle
    issue(3'd2);
    for (int i = 1; i <= 4; i++) begin
      chk("ldm_req",   32'(bus.mem_rd_req), 1);
      chk("ldm_ready", 32'(bus.op_ready),   0);
      if (i == 4) bus.mem_rd_ack = 1'b1;
      tick();
    end
    bus.mem_rd_ack = 1'b0;
    chk("ldm_req_drop", 32'(bus.mem_rd_req), 0);
    chk("ldm_write",    32'(bus.acc_write),  1);
    chk("ldm_sel",      32'(bus.acc_sel),    2);
    chk("ldm_wbcnt",    32'(bus.wb_count),   3);
    tick();
    chk("ldm_write_end", 32'(bus.acc_write), 0);

    // LDM, ack on the 15th (last) wait cycle still wins
    issue(3'd2);
    for (int i = 1; i <= 15; i++) begin
      if (i == 15) bus.mem_rd_ack = 1'b1;
      tick();
    end
    bus.mem_rd_ack = 1'b0;
    chk("edge_ack_write", 32'(bus.acc_write),   1);
    chk("edge_ack_err",   32'(bus.timeout_err), 0);
    chk("edge_ack_wbcnt", 32'(bus.wb_count),    4);
    tick();

    // LDM, no ack: abort after 15 wait cycles
    issue(3'd2);
    for (int i = 1; i <= 15; i++) begin
      chk("to_req_held", 32'(bus.mem_rd_req), 1);
      tick();
    end
    chk("to_req",   32'(bus.mem_rd_req),  0);
    chk("to_err",   32'(bus.timeout_err), 1);
    chk("to_write", 32'(bus.acc_write),   0);
    chk("to_wbcnt", 32'(bus.wb_count),    4);
    chk("to_ready", 32'(bus.op_ready),    1);

    // ALU with done in the second wait cycle, then STA
    issue(3'd3);
    chk("alu_start", 32'(bus.alu_start), 1);
    tick();
    chk("alu_start_end", 32'(bus.alu_start), 0);
    bus.alu_done = 1'b1;
    tick();
    bus.alu_done = 1'b0;
    chk("alu_write", 32'(bus.acc_write), 1);
    chk("alu_sel",   32'(bus.acc_sel),   3);
    chk("alu_wbcnt", 32'(bus.wb_count),  5);
    tick();
    issue(3'd4);
    chk("sta_regw",  32'(bus.reg_write), 1);
    chk("sta_write", 32'(bus.acc_write), 0);
    chk("sta_sel",   32'(bus.acc_sel),   3);
    chk("sta_ready", 32'(bus.op_ready),  1);
    tick();
    chk("sta_regw_end", 32'(bus.reg_write), 0);

    // Reserved op, HALT, then ignored LDI
    issue(3'd7);
    chk("ill_flag",  32'(bus.illegal_op), 1);
    chk("ill_ready", 32'(bus.op_ready),   1);
    issue(3'd6);
    chk("halt_flag",  32'(bus.halted),   1);
    chk("halt_ready", 32'(bus.op_ready), 0);
    bus.op_valid = 1'b1;
    bus.op_class = 3'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_no_write", 32'(bus.acc_write), 0);
    end
    bus.op_valid = 1'b0;
    chk("halt_wbcnt", 32'(bus.wb_count), 5);
    chk("halt_stay",  32'(bus.halted),   1);

    // Asynchronous reset clears everything mid-cycle
    reset = 1'b1;
    #1;
    chk("ar_halted", 32'(bus.halted),      0);
    chk("ar_ill",    32'(bus.illegal_op),  0);
    chk("ar_err",    32'(bus.timeout_err), 0);
    chk("ar_wbcnt",  32'(bus.wb_count),    0);
    chk("ar_sel",    32'(bus.acc_sel),     0);
    chk("ar_ready",  32'(bus.op_ready),    1);
    tick();
    reset = 1'b0;
    tick();

    // 256 LDI writes wrap the writeback counter
    for (int i = 1; i <= 256; i++) begin
      issue(3'd0);
      if (i == 255) chk("wrap_255", 32'(bus.wb_count), 255);
      tick();
    end
    chk("wrap_0", 32'(bus.wb_count), 0);

    // Reset while waiting on memory drops the request with no write
    issue(3'd2);
    tick();
    chk("rm_req", 32'(bus.mem_rd_req), 1);
    reset = 1'b1;
    #1;
    chk("rm_req_drop", 32'(bus.mem_rd_req), 0);
    bus.mem_rd_ack = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    bus.mem_rd_ack = 1'b0;
    chk("rm_no_write", 32'(bus.acc_write), 0);
    chk("rm_wbcnt",    32'(bus.wb_count),  0);
    chk("rm_ready",    32'(bus.op_ready),  1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/acc_sequencer.md
ACC_SEQUENCER -- requirements
Module: acc_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum MEM_WAIT/ALU_WAIT cycles before abort (legal range 1-255).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-004 op_valid  input  1  decoded operation offered this cycle.
REQ-005 op_class  input  3  0 LDI, 1 LDR, 2 LDM, 3 ALU, 4 STA, 5 NOP, 6 HALT, 7 reserved.
REQ-006 op_ready  output  1  sequencer can accept an operation this cycle.
REQ-007 mem_rd_req  output  1  data-memory read request, level, held until ack or abort.
REQ-008 mem_rd_ack  input  1  memory read data valid this cycle.
REQ-009 alu_start  output  1  one-cycle pulse starting the ALU.
REQ-010 alu_done  input  1  ALU result valid this cycle.
REQ-011 acc_sel  output  2  accumulator source select: 00 imm, 01 reg, 10 mem, 11 alu.
REQ-012 acc_write  output  1  accumulator write enable, one-cycle pulse.
REQ-013 reg_write  output  1  register-file write of accumulator value (STA), one-cycle pulse.
REQ-014 wb_count  output  8  count of acc_write pulses since reset.
REQ-015 timeout_err  output  1  sticky: a wait state aborted on timeout.
REQ-016 illegal_op  output  1  sticky: op_class 7 accepted.
REQ-017 halted  output  1  sequencer in HALT.

Function
REQ-018 The sequencer SHALL implement states IDLE, MEM_WAIT, ALU_WAIT, WRITEBACK, HALT; all outputs except op_ready SHALL be registered.
REQ-019 op_ready SHALL equal (state==IDLE); an operation is accepted only on a rising edge where op_valid & op_ready and reset is low.
REQ-020 Accept LDI/LDR: acc_sel <= 00/01, state -> WRITEBACK.
REQ-021 Accept LDM: mem_rd_req <= 1, state -> MEM_WAIT, wait counter <= 0.
REQ-022 Accept ALU: alu_start high for exactly the next cycle, state -> ALU_WAIT, wait counter <= 0.
REQ-023 Accept STA: reg_write high for exactly the next cycle, state stays IDLE, acc_sel and acc_write unchanged.
REQ-024 Accept NOP: no output change, state stays IDLE.
REQ-025 Accept reserved (7): behaves as NOP and sets illegal_op.
REQ-026 Accept HALT: state -> HALT; halted=1, op_ready=0; exit only by reset.
REQ-027 MEM_WAIT: mem_rd_ack=1 -> mem_rd_req <= 0, acc_sel <= 10, state -> WRITEBACK; else wait counter increments.
REQ-028 ALU_WAIT: alu_done=1 -> acc_sel <= 11, state -> WRITEBACK; else wait counter increments; alu_done outside ALU_WAIT SHALL be ignored.
REQ-029 Timeout: wait counter reaching MEM_TIMEOUT without ack/done -> mem_rd_req <= 0, timeout_err <= 1, state -> IDLE, no acc_write.
REQ-030 Ack/done in the same cycle the counter reaches MEM_TIMEOUT SHALL win: normal WRITEBACK, no timeout_err.
REQ-031 WRITEBACK: acc_write=1 for exactly one cycle, wb_count increments (wraps 255 -> 0), state -> IDLE.
REQ-032 acc_sel SHALL hold its value from entry into WRITEBACK until the next LDI/LDR/LDM-ack/ALU-done update, so it is stable throughout every acc_write pulse.
REQ-033 Latency: LDI/LDR accepted at edge N -> acc_write high cycle N+1; LDM/ALU -> acc_write high the cycle after the ack/done edge; max issue rate one load per 2 cycles.
REQ-034 mem_rd_ack outside MEM_WAIT SHALL be ignored; op_valid outside IDLE SHALL be ignored (not queued).

Reset
REQ-035 reset assertion SHALL immediately force state IDLE and acc_sel=00, acc_write=0, reg_write=0, alu_start=0, mem_rd_req=0, wb_count=0, timeout_err=0, illegal_op=0, halted=0.
REQ-036 Reset mid-operation (any wait state or WRITEBACK) SHALL abandon the operation with no acc_write; op_ready=1 from the first edge after deassertion.

Verification
REQ-037 LDI at edge 1 then LDR at edge 3 -> acc_write cycles 2 and 4, acc_sel 00 then 01, wb_count=2.
REQ-038 LDM, mem_rd_ack after 3 wait cycles -> mem_rd_req high 4 cycles, acc_sel=10, one acc_write, op_ready low throughout.
REQ-039 LDM, no ack, MEM_TIMEOUT=15 -> after 15 wait cycles mem_rd_req=0, timeout_err=1, wb_count unchanged; ack on exact 15th cycle -> write, no error.
REQ-040 ALU op with alu_done after 2 cycles, then STA -> alu_start single pulse, acc_sel=11 write, reg_write single pulse, acc_sel still 11.
REQ-041 op_class 7, then HALT, then LDI offered -> illegal_op=1, halted=1, op_ready=0, no acc_write; reset -> all outputs cleared.
REQ-042 256 LDI writes -> wb_count wraps to 0; reset asserted in MEM_WAIT -> mem_rd_req drops asynchronously, no acc_write.
